// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, key schedule unwound on the fly.
// Define AES_DEC_KEY_CACHE_EN to reuse the last expanded round-10 key when the cipher key repeats.
module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [2:0] {IDLE, EXPAND, ADD, ROUND, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] data_reg, rk_reg, rk_load;
  logic [127:0] rk_fwd, rk_prev, ark, imc, round_nxt;
  logic [3:0]   rnd;
  logic         accept, hit;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 via an addition chain (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = x;
    for (int unsigned i = 0; i < 6; i++) t = gm(gm(t, t), x);
    return gm(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  always_comb begin : key_sched
    logic [31:0] n0, n1, n2, n3, p0, p1, p2, p3;
    n0 = rk_reg[127:96] ^ sub_rot(rk_reg[31:0]) ^ {rcon(rnd), 24'h0};
    n1 = rk_reg[95:64] ^ n0;
    n2 = rk_reg[63:32] ^ n1;
    n3 = rk_reg[31:0] ^ n2;
    rk_fwd = {n0, n1, n2, n3};
    // rk_reg holds rk(rnd+1) during ROUND, so its predecessor needs Rcon[rnd+1].
    p3 = rk_reg[31:0] ^ rk_reg[63:32];
    p2 = rk_reg[63:32] ^ rk_reg[95:64];
    p1 = rk_reg[95:64] ^ rk_reg[127:96];
    p0 = rk_reg[127:96] ^ sub_rot(p3) ^ {rcon(rnd + 4'd1), 24'h0};
    rk_prev = {p0, p1, p2, p3};
  end

  always_comb begin : inv_round
    logic [7:0] a0, a1, a2, a3;
    ark = '0;
    imc = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    // Output byte (row r, col c) takes input column (c - r) mod 4.
    for (int unsigned i = 0; i < 16; i++) begin
      ark[127-8*i -: 8] = inv_sbox(data_reg[127-8*(4*(((i/4)+4-(i%4))%4)+(i%4)) -: 8])
                          ^ rk_prev[127-8*i -: 8];
    end
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = ark[127-32*c -: 8];
      a1 = ark[119-32*c -: 8];
      a2 = ark[111-32*c -: 8];
      a3 = ark[103-32*c -: 8];
      imc[127-32*c -: 32] = {gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
                             gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
                             gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
                             gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
    end
    round_nxt = (rnd == 4'd0) ? ark : imc;
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key, cache_rk10;
  logic         cache_vld;

  assign hit     = cache_vld && (in_key == cache_key);
  assign rk_load = hit ? cache_rk10 : in_key;

  // Key is recorded at a missing accept and validated when EXPAND completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key  <= '0;
      cache_rk10 <= '0;
      cache_vld  <= 1'b0;
    end else if (accept && !hit) begin
      cache_key <= in_key;
      cache_vld <= 1'b0;
    end else if (state == EXPAND && rnd == 4'd10) begin
      cache_rk10 <= rk_fwd;
      cache_vld  <= 1'b1;
    end
  end
`else
  assign hit     = 1'b0;
  assign rk_load = in_key;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    out_data  = (state == DONE) ? data_reg : '0;
    accept    = in_valid && (state == IDLE);
    case (state)
      IDLE:    if (accept) state_nxt = hit ? ADD : EXPAND;
      EXPAND:  if (rnd == 4'd10) state_nxt = ADD;
      ADD:     state_nxt = ROUND;
      ROUND:   if (rnd == 4'd0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      rk_reg   <= '0;
      rnd      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          data_reg <= in_data;
          rk_reg   <= rk_load;
          rnd      <= 4'd1;
        end
        EXPAND: begin
          rk_reg <= rk_fwd;
          rnd    <= rnd + 4'd1;
        end
        ADD: begin
          data_reg <= data_reg ^ rk_reg;
          rnd      <= 4'd9;
        end
        ROUND: begin
          data_reg <= round_nxt;
          rk_reg   <= rk_prev;
          rnd      <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: known-answer and random blocks against a FIPS-197 style model,
// with handshake stalls, ignored inputs and a mid-operation reset.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit [7:0]    sb [256];
  bit [7:0]    isb [256];
  bit          cache_ok = 1'b0;
  bit [127:0]  cache_k = '0;

  localparam bit [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam bit [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam bit [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam bit [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam bit [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam bit [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] p = 0;
    bit [8:0] x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x[7:0];
      x = x << 1;
      if (x[8]) x ^= 9'h11b;
    end
    return p;
  endfunction

  // S-boxes from brute-force inverse search plus the bitwise affine map.
  task automatic build_tables();
    bit [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      bit [7:0] inv = 0;
      bit [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic bit [127:0] ref_decrypt(input bit [127:0] ct, input bit [127:0] key);
    bit [31:0] w [44];
    bit [7:0]  st [16];
    bit [7:0]  t [16];
    bit [31:0] tmp;
    bit [7:0]  rc = 8'h01;
    bit [7:0]  a0, a1, a2, a3;
    bit [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) st[j] = ct[127-8*j -: 8] ^ w[40 + j/4][31-8*(j%4) -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*((c+r)%4)] = st[r + 4*c];
      for (int j = 0; j < 16; j++) st[j] = isb[t[j]] ^ w[4*rd + j/4][31-8*(j%4) -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
          st[4*c+1] = gmul(a0, 9)  ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
          st[4*c+2] = gmul(a0, 13) ^ gmul(a1, 9)  ^ gmul(a2, 14) ^ gmul(a3, 11);
          st[4*c+3] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9)  ^ gmul(a3, 14);
        end
      end
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = st[j];
    return res;
  endfunction

  function automatic bit [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int exp_latency(input bit [127:0] key);
`ifdef AES_DEC_KEY_CACHE_EN
    return (cache_ok && key == cache_k) ? 12 : 22;
`else
    return 22;
`endif
  endfunction

  // Accept one block, wait for the result, optionally stall, then complete the handshake.
  task automatic run_block(input bit [127:0] ct, input bit [127:0] key, input bit [127:0] pt,
                           input int hold, input int glitch, input string tag);
    int cyc;
    int lat;
    logic [127:0] held;
    lat = exp_latency(key);
    @(negedge clk);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = ct;
    in_key   = key;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
    in_key   = rand128();
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      if (glitch != 0 && cyc == glitch) begin
        in_valid = 1'b1;
        in_data  = rand128();
        in_key   = rand128();
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_latency"}, 128'(cyc), 128'(lat));
    check({tag, "_data"}, out_data, pt);
    held = out_data;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
      check({tag, "_hold_data"}, out_data, held);
      check({tag, "_hold_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_post_ready"}, 128'(in_ready), 128'(1));
    cache_ok = 1'b1;
    cache_k  = key;
  endtask

  initial begin
    int cyc;
    int highs;
    bit [127:0] k, c, prev_k;
    build_tables();

    repeat (2) @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_data", out_data, 128'(0));
    rst_n = 1'b1;

    run_block(CT1, KEY1, PT1, 0, 0, "kat1");
    run_block(CT1, KEY1, PT1, 5, 15, "kat1_stall_glitch");
    @(negedge clk);
    check("no_second_output", 128'(out_valid), 128'(0));
    run_block(CT2, KEY2, PT2, 0, 0, "kat2");

    // Abort a block with a one-cycle reset pulse at T+15.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = CT1;
    in_key   = KEY1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    cache_ok = 1'b0;
    #1;
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    check("abort_no_output", 128'(highs), 128'(0));
    check("abort_idle", 128'(in_ready), 128'(1));
    run_block(CT2, KEY2, PT2, 0, 0, "after_abort");

    prev_k = KEY2;
    for (int i = 0; i < 8; i++) begin
      k = (i % 3 == 1) ? prev_k : rand128();
      c = rand128();
      run_block(c, k, ref_decrypt(c, k), i % 3, (i % 2 == 0) ? 14 : 0, $sformatf("rand%0d", i));
      prev_k = k;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
